// File: rtl/irq_onehot_latch.sv
// irq_onehot_latch: latches request lines into a pending register and presents
// the highest-index eligible request as a registered one-hot grant. A grant
// stays stable until the consumer acknowledges it. Every output comes from a
// flop, so no input reaches an output combinationally.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no grant shown; load the best eligible bit at the next edge
//   PRESENT | grant held in onehot_out with valid=1 until ack
module irq_onehot_latch #(
    parameter int N    = 8,
    parameter int EDGE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [N-1:0] onehot_out,
    output logic         valid,
    output logic [N-1:0] pending_out,
    output logic         overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] req_q;
    logic [N-1:0] pending;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] pending_next;
    logic         overflow_next;
    logic [N-1:0] elig;
    logic [N-1:0] sel;
    logic [N-1:0] onehot_next;
    logic         valid_next;

    assign pending_out = pending;

    // Capture, clear and overflow detection for the pending register.
    // A fresh set beats a clear on the same bit, so a request that re-arrives
    // while it is being acknowledged is never lost.
    always_comb begin
        set           = '0;
        clr           = '0;
        overflow_next = 1'b0;
        if (EDGE != 0) begin
            set = req_in & ~req_q;
        end else begin
            set = req_in;
        end
        if (valid && ack) begin
            clr = onehot_out;
        end
        pending_next = (pending & ~clr) | set;
        if (EDGE != 0) begin
            overflow_next = |(set & pending & ~clr);
        end
    end

    // Highest-index eligible bit wins, matching the downstream encoder priority.
    always_comb begin
        elig = pending & ~mask;
        sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    // Grant FSM next-state and registered-output values.
    always_comb begin
        state_next  = state;
        onehot_next = onehot_out;
        valid_next  = valid;
        case (state)
            IDLE: begin
                onehot_next = '0;
                valid_next  = 1'b0;
                if (|elig) begin
                    state_next  = PRESENT;
                    onehot_next = sel;
                    valid_next  = 1'b1;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_next  = IDLE;
                    onehot_next = '0;
                    valid_next  = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                onehot_next = '0;
                valid_next  = 1'b0;
            end
        endcase
    end

    // State, grant, pending and edge-history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            onehot_out <= '0;
            valid      <= 1'b0;
            pending    <= '0;
            req_q      <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            onehot_out <= onehot_next;
            valid      <= valid_next;
            pending    <= pending_next;
            req_q      <= req_in;
            overflow   <= overflow_next;
        end
    end

    // The encoder downstream relies on seeing zero or exactly one set bit.
    a_onehot : assert property (@(posedge clk) disable iff (rst)
        ($countones(onehot_out) <= 1) && ((onehot_out != '0) == valid));

endmodule

// File: doc/irq_onehot_latch.md
Name: irq_onehot_latch

Overview:
- Upstream stage of the 8-to-3 priority encoder.
- Captures asynchronous-in-meaning request lines into a pending register and selects the highest-index eligible request.
- Presents the selection as a strictly one-hot vector with a valid/ack handshake, so the encoder always sees 0 or a single set bit.
- Clears each request only when the consumer acknowledges it.

Parameters:
- N, 8, number of request lines; default matches the 8-bit encoder input.
- EDGE, 1, 1 = rising-edge request capture; 0 = level capture.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_in  input  N  request lines, bit i = source i, already synchronised to clk
- mask  input  N  1 = source not eligible for selection (still latched as pending)
- ack  input  1  consumer accepts current onehot_out; meaningful only when valid=1
- onehot_out  output  N  registered one-hot selection; all-zero when valid=0
- valid  output  1  onehot_out holds a selection
- pending_out  output  N  current pending register
- overflow  output  1  one-cycle pulse: an edge arrived on an already-pending, not-being-cleared bit

Behaviour:
- Reset: one clock, rst=1 sampled at an edge. Afterwards pending=0, req_q=0, onehot_out=0, valid=0, overflow=0, state=IDLE.
- Reset mid-grant drops valid and discards all pending requests.
- Because req_q resets to 0, a line held high across reset release is seen as a rising edge at the first edge with rst=0 (EDGE=1).
- Capture, EDGE=1: set_i = req_in[i] & ~req_q[i]. req_q is updated every edge.
- Capture, EDGE=0: set_i = req_in[i].
- Pending update each edge: pending_next = (pending & ~clr) | set.
  - clr = onehot_out when valid & ack, else 0.
  - Set wins over clear on the same bit in the same cycle.
- Overflow (EDGE=1 only; always 0 when EDGE=0): overflow_next = |(set & pending & ~clr). Registered, so it pulses for one cycle.
- Eligibility: elig = pending & ~mask. Select the highest index, bit N-1 first, matching encoder priority.
- State IDLE:
  - valid=0, onehot_out=0.
  - At an edge with elig != 0: load onehot_out with the highest-priority bit, set valid=1, go to PRESENT.
- State PRESENT:
  - onehot_out and valid held stable while ack=0. Changes to mask, req_in or pending do not alter the current grant.
  - At an edge with ack=1: clear that pending bit (subject to the set-wins rule), drive valid=0 and onehot_out=0, go to IDLE.
- Latency:
  - Edge sampled at edge k → pending bit set after edge k → valid=1 after edge k+1, if IDLE and eligible.
  - After an ack at edge m, the next grant appears no earlier than after edge m+1. There is an idle gap of at least one cycle between grants; maximum throughput is one grant per 2 cycles.
- ack while valid=0 is ignored.
- A masked bit stays pending indefinitely. It becomes selectable in the IDLE cycle after its mask bit clears.
- EDGE=0 with req_in held high: the bit re-pends in the ack cycle, so it is re-granted 2 cycles later.
- Invariant: $countones(onehot_out) ≤ 1, and onehot_out != 0 iff valid=1.
- No combinational path from any input to any output.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles with req_in=8'hFF, EDGE=1, then rst=0 → pending_out=8'hFF after the first edge, valid=1 and onehot_out=8'h80 one edge later; with rst held 1, all outputs stay 0.
2. Priority drain: single-cycle pulse req_in=8'b0010_0101, mask=0, ack tied high → grants appear in order 8'h20, 8'h04, 8'h01, each valid for 1 cycle with 1 idle cycle between, then pending_out=0.
3. Hold under backpressure: grant 8'h04 presented, ack=0 for 5 cycles while req_in pulses bit 7 → onehot_out stays 8'h04, pending_out=8'h84; ack=1 → valid=0 next cycle, then onehot_out=8'h80.
4. Overflow and set-wins: bit 3 pending and not granted, second edge on bit 3 → overflow=1 for exactly one cycle, pending unchanged. Edge on bit 3 in the same cycle as its ack → pending[3] remains 1, overflow=0, bit 3 re-granted.
5. Mask: pending=8'h81, mask=8'h80 → grant 8'h01. After ack, pending=8'h80 and valid stays 0; clear mask → onehot_out=8'h80 after the next edge.
6. Reset mid-grant: valid=1, onehot_out=8'h10, pending=8'h1C, assert rst for one edge → valid=0, onehot_out=0, pending_out=0, overflow=0 after that edge; no grant follows without new edges.
